// File: rtl/dmem_responder_if.sv
// Purpose: bundles the core data-memory port and the host preload/readback port.
// Latency: none, wiring only.
// Backpressure: host requests are held until host_ack; the core port is never stalled.
interface dmem_responder_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 32
);
  // core side
  logic                     mem_enable;
  logic                     store_enable;
  logic [ADDRESS_WIDTH-1:0] dmem_address;
  logic [DATA_WIDTH-1:0]    dmem_dataIn;
  logic [DATA_WIDTH-1:0]    dmem_dataOut;
  // host side
  logic                     host_req;
  logic                     host_we;
  logic [ADDRESS_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0]    host_wdata;
  logic [DATA_WIDTH-1:0]    host_rdata;
  logic                     host_ack;
  // status
  logic                     ready;
  logic [1:0]               err;

  modport master (
    output mem_enable, store_enable, dmem_address, dmem_dataIn,
    output host_req, host_we, host_addr, host_wdata,
    input  dmem_dataOut, host_rdata, host_ack, ready, err
  );

  modport slave (
    input  mem_enable, store_enable, dmem_address, dmem_dataIn,
    input  host_req, host_we, host_addr, host_wdata,
    output dmem_dataOut, host_rdata, host_ack, ready, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Purpose: synchronous word RAM serving core loads/stores plus a lower-priority host port; zero-cleared after reset.
// Latency: load data and host ack/rdata one cycle after the access; clear takes DEPTH cycles.
// Backpressure: core always wins; host waits while mem_enable is high and is accepted at most every 2nd cycle.
module dmem_responder #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_LOG2    = 8
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [DEPTH_LOG2-1:0]  clr_idx;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic [DEPTH_LOG2-1:0]  core_idx;
  logic [DEPTH_LOG2-1:0]  host_idx;
  logic                   core_in_range;
  logic                   host_in_range;
  logic                   idle;
  logic                   core_acc;
  logic                   core_ld;
  logic                   host_acc;

  logic                   wr_en;
  logic [DEPTH_LOG2-1:0]  wr_idx;
  logic [DATA_WIDTH-1:0]  wr_dat;

  assign core_idx      = bus.dmem_address[DEPTH_LOG2-1:0];
  assign host_idx      = bus.host_addr[DEPTH_LOG2-1:0];
  assign core_in_range = (bus.dmem_address[ADDRESS_WIDTH-1:DEPTH_LOG2] == '0);
  assign host_in_range = (bus.host_addr[ADDRESS_WIDTH-1:DEPTH_LOG2] == '0);

  // State register and clear index; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  // Leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_idx == DEPTH_LOG2'(DEPTH - 1)) state_nxt = IDLE;
  end

  // Decode service status and which port owns the RAM this cycle.
  always_comb begin
    idle      = (state == IDLE);
    bus.ready = idle;
    core_acc  = idle && bus.mem_enable;
    core_ld   = core_acc && !bus.store_enable;
    // host_ack high means an access was just taken, which spaces host accesses 2 cycles apart
    host_acc  = idle && bus.host_req && !bus.mem_enable && !bus.host_ack;
  end

  // Single write port: clear, core store or host write, never two at once.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = clr_idx;
    wr_dat = '0;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en = 1'b1;
      end else if (core_acc && bus.store_enable && core_in_range) begin
        wr_en  = 1'b1;
        wr_idx = core_idx;
        wr_dat = bus.dmem_dataIn;
      end else if (host_acc && bus.host_we && host_in_range) begin
        wr_en  = 1'b1;
        wr_idx = host_idx;
        wr_dat = bus.host_wdata;
      end
    end
  end

  // RAM array write, no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_dat;
  end

  // Registered read data, host ack pulse and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dmem_dataOut <= '0;
      bus.host_rdata   <= '0;
      bus.host_ack     <= 1'b0;
      bus.err          <= 2'b00;
    end else begin
      bus.host_ack <= host_acc;
      if (core_ld) bus.dmem_dataOut <= core_in_range ? mem[core_idx] : '0;
      if (host_acc && !bus.host_we) bus.host_rdata <= host_in_range ? mem[host_idx] : '0;
      if ((core_acc && !core_in_range) || (host_acc && !host_in_range)) bus.err[0] <= 1'b1;
      if (state == CLEAR && bus.mem_enable) bus.err[1] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Purpose: checks dmem_responder against a word-array reference model with directed and random traffic.
// Latency: model predicts every output one edge after the inputs it consumes.
// Backpressure: host driver holds its request until it sees host_ack.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dmem_responder_if bus ();

  dmem_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [63:0] m_mem [256];
  logic [63:0] m_dout;
  logic [63:0] m_hrd;
  logic        m_ack;
  logic        m_ready;
  logic [1:0]  m_err;
  int          m_cnt;

  // Advance model by one clock using the inputs currently driven, then step the DUT.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    if (rst) begin
      m_err = 2'b00; m_dout = '0; m_hrd = '0; m_ack = 1'b0; m_ready = 1'b0; m_cnt = 0;
      for (int i = 0; i < 256; i++) m_mem[i] = '0;
    end else if (!m_ready) begin
      if (bus.mem_enable) m_err[1] = 1'b1;
      m_cnt++;
      if (m_cnt == 256) m_ready = 1'b1;
      m_ack = 1'b0;
    end else begin
      acc = bus.host_req && !bus.mem_enable && !m_ack;
      if (bus.mem_enable) begin
        a = bus.dmem_address;
        if (a >= 256) begin
          m_err[0] = 1'b1;
          if (!bus.store_enable) m_dout = '0;
        end else if (bus.store_enable) m_mem[a[7:0]] = bus.dmem_dataIn;
        else m_dout = m_mem[a[7:0]];
      end
      if (acc) begin
        a = bus.host_addr;
        if (a >= 256) begin
          m_err[0] = 1'b1;
          if (!bus.host_we) m_hrd = '0;
        end else if (bus.host_we) m_mem[a[7:0]] = bus.host_wdata;
        else m_hrd = m_mem[a[7:0]];
      end
      m_ack = acc;
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one host access and wait (bounded) for its ack; lat = -1 on timeout.
  task automatic do_host(input logic we, input logic [31:0] addr, input logic [63:0] wdata, output int lat);
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (bus.host_ack === 1'b1) begin lat = i; break; end
    end
    bus.host_req = 1'b0;
  endtask

  task automatic core_op(input logic st, input logic [31:0] addr, input logic [63:0] d);
    bus.mem_enable = 1'b1; bus.store_enable = st; bus.dmem_address = addr; bus.dmem_dataIn = d;
    cycle();
    bus.mem_enable = 1'b0; bus.store_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(); cycle();
    checks++;
    if (bus.dmem_dataOut !== 64'h0 || bus.host_rdata !== 64'h0 || bus.host_ack !== 1'b0 ||
        bus.ready !== 1'b0 || bus.err !== 2'b00) begin
      errors++;
      $display("FAIL reset_values: dout=%h hrd=%h ack=%b ready=%b err=%b, required all zero",
               bus.dmem_dataOut, bus.host_rdata, bus.host_ack, bus.ready, bus.err);
    end
    rst = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      cycle();
      checks++;
      if (bus.ready !== (i == 256)) begin
        errors++;
        $display("FAIL clear_ready edge %0d: ready=%b required %b", i, bus.ready, i == 256);
      end
    end
  endtask

  task automatic test_clear_host_reads();
    logic [31:0] addrs [3] = '{32'd0, 32'd17, 32'd255};
    int lat;
    foreach (addrs[k]) begin
      do_host(1'b0, addrs[k], 64'h0, lat);
      checks++;
      if (lat != 1 || bus.host_rdata !== 64'h0 || bus.err !== 2'b00) begin
        errors++;
        $display("FAIL clear_read word %0d: lat=%0d rdata=%h err=%b, required lat=1 rdata=0 err=00",
                 addrs[k], lat, bus.host_rdata, bus.err);
      end
      cycle();
    end
  endtask

  task automatic test_store_load();
    core_op(1'b1, 32'd5, 64'hDEAD_BEEF_0123_4567);
    core_op(1'b0, 32'd5, 64'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.dmem_dataOut !== 64'hDEAD_BEEF_0123_4567) begin
        errors++;
        $display("FAIL store_load cycle %0d: dout=%h required %h", i, bus.dmem_dataOut, 64'hDEAD_BEEF_0123_4567);
      end
      if (i < 3) cycle();
    end
  endtask

  task automatic test_arbitration();
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'd5;
    bus.mem_enable = 1'b1; bus.store_enable = 1'b0; bus.dmem_address = 32'd7;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (bus.host_ack !== 1'b0) begin
        errors++;
        $display("FAIL arb_stall cycle %0d: host_ack=%b required 0", i, bus.host_ack);
      end
    end
    bus.mem_enable = 1'b0;
    cycle();
    checks++;
    if (bus.host_ack !== 1'b1 || bus.host_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      errors++;
      $display("FAIL arb_grant: ack=%b rdata=%h required ack=1 rdata=%h",
               bus.host_ack, bus.host_rdata, 64'hDEAD_BEEF_0123_4567);
    end
    bus.host_req = 1'b0;
    cycle();
    checks++;
    if (bus.host_ack !== 1'b0) begin
      errors++;
      $display("FAIL arb_ack_pulse: host_ack=%b required 0", bus.host_ack);
    end
  endtask

  task automatic test_host_preload();
    int lat;
    do_host(1'b1, 32'd9, 64'h1, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL preload_ack: latency=%0d required 1", lat);
    end
    core_op(1'b0, 32'd9, 64'h0);
    checks++;
    if (bus.dmem_dataOut !== 64'h1) begin
      errors++;
      $display("FAIL preload_core_read: dout=%h required 1", bus.dmem_dataOut);
    end
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 32'd9;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      checks++;
      if (bus.host_ack !== logic'(i % 2 == 1)) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: host_ack=%b required %b", i, bus.host_ack, i % 2 == 1);
      end
    end
    bus.host_req = 1'b0;
    cycle();
  endtask

  task automatic test_out_of_range();
    int lat;
    do_host(1'b1, 32'd3, 64'hCAFE, lat);
    core_op(1'b0, 32'h0000_0100, 64'h0);
    checks++;
    if (bus.dmem_dataOut !== 64'h0 || bus.err[0] !== 1'b1) begin
      errors++;
      $display("FAIL oor_load: dout=%h err0=%b required dout=0 err0=1", bus.dmem_dataOut, bus.err[0]);
    end
    core_op(1'b1, 32'h0001_0003, 64'hFFFF_FFFF_FFFF_FFFF);
    do_host(1'b0, 32'd3, 64'h0, lat);
    checks++;
    if (bus.host_rdata !== 64'hCAFE) begin
      errors++;
      $display("FAIL oor_store_dropped: word3=%h required %h", bus.host_rdata, 64'hCAFE);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      bus.mem_enable   = ($urandom_range(0, 1) == 1);
      bus.store_enable = ($urandom_range(0, 1) == 1);
      bus.dmem_address = ($urandom_range(0, 15) == 0) ? 32'h100 + $urandom_range(0, 5000) : $urandom_range(0, 255);
      bus.dmem_dataIn  = {$urandom, $urandom};
      if (!bus.host_req || m_ack) begin
        bus.host_req   = ($urandom_range(0, 2) != 0);
        bus.host_we    = ($urandom_range(0, 1) == 1);
        bus.host_addr  = ($urandom_range(0, 15) == 0) ? 32'h100 + $urandom_range(0, 5000) : $urandom_range(0, 255);
        bus.host_wdata = {$urandom, $urandom};
      end
      cycle();
      checks++;
      if (bus.dmem_dataOut !== m_dout || bus.host_rdata !== m_hrd || bus.host_ack !== m_ack ||
          bus.ready !== m_ready || bus.err !== m_err) begin
        errors++;
        $display("FAIL random step %0d: dout=%h hrd=%h ack=%b rdy=%b err=%b required dout=%h hrd=%h ack=%b rdy=%b err=%b",
                 n, bus.dmem_dataOut, bus.host_rdata, bus.host_ack, bus.ready, bus.err,
                 m_dout, m_hrd, m_ack, m_ready, m_err);
      end
    end
    bus.mem_enable = 1'b0;
    bus.host_req   = 1'b0;
    cycle(); cycle();
  endtask

  task automatic test_mid_clear();
    int lat;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) cycle();
    core_op(1'b1, 32'd2, 64'h1234_5678_9ABC_DEF0);
    checks++;
    if (bus.err !== 2'b10 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_access: err=%b ready=%b required err=10 ready=0", bus.err, bus.ready);
    end
    for (int i = 11; i <= 99; i++) cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if (bus.err !== 2'b00 || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear_reset: err=%b ready=%b required err=00 ready=0", bus.err, bus.ready);
    end
    rst = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      cycle();
      checks++;
      if (bus.ready !== (i == 256)) begin
        errors++;
        $display("FAIL reclear_ready edge %0d: ready=%b required %b", i, bus.ready, i == 256);
      end
    end
    do_host(1'b0, 32'd2, 64'h0, lat);
    checks++;
    if (lat != 1 || bus.host_rdata !== 64'h0) begin
      errors++;
      $display("FAIL word2_cleared: lat=%0d rdata=%h required lat=1 rdata=0", lat, bus.host_rdata);
    end
  endtask

  initial begin
    bus.mem_enable = 1'b0; bus.store_enable = 1'b0; bus.dmem_address = '0; bus.dmem_dataIn = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    m_err = 2'b00; m_dout = '0; m_hrd = '0; m_ack = 1'b0; m_ready = 1'b0; m_cnt = 0;
    test_reset();
    test_clear_host_reads();
    test_store_load();
    test_arbitration();
    test_host_preload();
    test_out_of_range();
    test_random();
    test_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 4-stage pipeline: the memory side of the `dmem_address` / `dmem_dataIn` / `store_enable` / `mem_enable` / `dmem_dataOut` interface the core drives from stage 2 and samples in stage 3. It holds a synchronous 64-bit-word RAM and zero-clears it after reset under an FSM. It also arbitrates a secondary host port, used for program/data preload and readback, at lower priority than the core.

## Interface
- DATA_WIDTH, 64, word width
- ADDRESS_WIDTH, 32, width of `dmem_address` and `host_addr`
- DEPTH_LOG2, 8, log2 of word count (DEPTH = 2^DEPTH_LOG2)

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- mem_enable  in  1  core memory access this cycle
- store_enable  in  1  with mem_enable: 1 = store, 0 = load
- dmem_address  in  ADDRESS_WIDTH  word address from core
- dmem_dataIn  in  DATA_WIDTH  store data from core
- dmem_dataOut  out  DATA_WIDTH  registered load data to core
- host_req  in  1  host access request (level)
- host_we  in  1  host write when 1, read when 0
- host_addr  in  ADDRESS_WIDTH  host word address
- host_wdata  in  DATA_WIDTH  host write data
- host_rdata  out  DATA_WIDTH  registered host read data
- host_ack  out  1  one-cycle pulse: host access performed
- ready  out  1  clear complete, memory in service
- err  out  2  sticky: [0] out-of-range access, [1] core access during clear

## Operation
- FSM states: CLEAR, IDLE. `rst` forces CLEAR with clear index 0; from any state, including mid-clear, it restarts the clear from index 0.
- CLEAR: each cycle write 0 to mem[idx] and increment idx. After writing index DEPTH-1, go to IDLE and set ready=1.
- CLEAR drops every core access and sets err[1]; dmem_dataOut holds its value. Host requests are not served in CLEAR and host_ack stays 0.
- IDLE, core access: the word index is dmem_address[DEPTH_LOG2-1:0].
  - In range (all higher address bits 0), store: mem[idx] <= dmem_dataIn.
  - In range, load: dmem_dataOut <= mem[idx].
  - Out of range: the store is dropped, a load returns 0, and err[0] is set.
- IDLE, no core access: dmem_dataOut holds its previous value.
- Host arbitration: the core always wins. A host access is accepted only in a cycle where state=IDLE, host_req=1, mem_enable=0 and host_ack=0, so at most one access is accepted every 2 cycles.
- Accepted host write: updates mem.
- Accepted host read: host_rdata <= mem[idx].
- Host out-of-range: the write is dropped, a read returns 0, err[0] is set, and the access is still acked.
- Host holds req/we/addr/wdata until it sees ack, then deasserts or presents the next request.
- Core store and host access never occur in the same cycle because of the arbitration rule, so there are no write conflicts.
- err bits clear only on rst.

## Timing
- Reset values: dmem_dataOut=0, host_rdata=0, host_ack=0, ready=0, err=2'b00, state=CLEAR, idx=0.
- Clear latency: ready reads 1 after the DEPTH-th rising edge with rst=0 (256 cycles at the default).
- Core load: address and mem_enable presented in cycle N; data valid on dmem_dataOut in cycle N+1 and held until the next load. This matches core stage-2 issue and stage-3 capture.
- Core store: mem updated at the end of cycle N. A load of the same address in N+1 returns the new data.
- Host: accepted in cycle N; host_ack=1 and host_rdata valid in cycle N+1; host_ack=0 in N+2.
  - While mem_enable stays high, the host is stalled indefinitely with no ack.
- Core load and a held host_req in the same cycle: the core is served and the host is accepted in the first later cycle with mem_enable=0.
- rst asserted in the same cycle as an access: reset wins and the access is dropped.

## Test plan
- Reset/clear: hold rst 2 cycles, then release.
  - ready=0 for 255 cycles and 1 after edge 256.
  - Host reads of words 0, 17 and 255 return 0 with err=0.
- Core store/load: store 64'hDEAD_BEEF_0123_4567 at address 5, then load 5 the next cycle → dmem_dataOut equals that value one cycle after the load and holds it through 3 idle cycles.
- Arbitration: host_req=1 read of addr 5 while mem_enable=1 for 4 cycles → no host_ack during those cycles. Ack arrives 1 cycle after mem_enable drops, with host_rdata = stored value.
- Host preload then core read: host write 64'h1 to addr 9, ack, then core load of 9 → dmem_dataOut=64'h1. A back-to-back held host_req is accepted only every 2nd cycle.
- Out of range: core load of 32'h0000_0100 → dmem_dataOut=0 and err[0]=1. A store to 32'h0001_0003 leaves word 3 unchanged.
- Mid-clear reset and during-clear access:
  - Core store to addr 2 at clear cycle 10 → dropped, err[1]=1.
  - Assert rst at clear cycle 100 → err=0 and ready is reached exactly 256 cycles after release.
  - Word 2 reads 0.
